// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - iterative radix-2 32x32 multiplier owning the HI/LO pair
module mult_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start_mult,
    input  logic        Mult_sign,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Hilo_read,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        Mult_stall
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start_mult) begin
                    // Signed operands are reduced to magnitudes; -2^31 stays 0x80000000 as unsigned.
                    mcand_d  = (Mult_sign && A[31]) ? (32'd0 - A) : A;
                    mplier_d = (Mult_sign && B[31]) ? (32'd0 - B) : B;
                    neg_d    = Mult_sign & (A[31] ^ B[31]);
                    acc_d    = 64'd0;
                    cnt_d    = 5'd0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + ({32'd0, mcand_q} << cnt_q);
                end
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                {hi_d, lo_d} = neg_q ? (64'd0 - acc_q) : acc_q;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign HI         = hi_q;
    assign LO         = lo_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign Mult_stall = busy_q & Hilo_read;

endmodule

// File: tb/tb_mult_unit.sv
// tb/tb_mult_unit.sv - scoreboard bench for mult_unit
module tb_mult_unit;

    logic        clk;
    logic        rst_n;
    logic        Start_mult;
    logic        Mult_sign;
    logic [31:0] A;
    logic [31:0] B;
    logic        Hilo_read;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        Mult_stall;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    mult_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Start_mult (Start_mult),
        .Mult_sign  (Mult_sign),
        .A          (A),
        .B          (B),
        .Hilo_read  (Hilo_read),
        .HI         (HI),
        .LO         (LO),
        .busy       (busy),
        .done       (done),
        .Mult_stall (Mult_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Drives a request away from the edge, records the expected product, returns just after E0.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        Start_mult = 1'b1;
        A          = a;
        B          = b;
        Mult_sign  = s;
        exp_q.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        Start_mult = 1'b0;
        A          = $urandom;
        B          = $urandom;
    endtask

    task automatic wait_done(input string tag, input int ign_at, input int read_at,
                             input logic chain, input logic [31:0] ca, input logic [31:0] cb,
                             input logic cs);
        int cyc = 0;
        int busy_cnt = 0;
        int stall_bad = 0;
        logic [63:0] exp;
        while (done !== 1'b1 && cyc < 100) begin
            Start_mult = (cyc == ign_at);
            if (cyc == ign_at) begin
                A         = 32'h0000_0100;
                B         = 32'h0000_0200;
                Mult_sign = 1'b0;
            end
            if (cyc == read_at) Hilo_read = 1'b1;
            #1;
            if (busy === 1'b1) busy_cnt++;
            if (read_at >= 0 && cyc >= read_at && Mult_stall !== 1'b1) stall_bad++;
            @(posedge clk);
            #1;
            Start_mult = 1'b0;
            cyc++;
        end
        check({tag, "_timeout"}, 64'(cyc < 100), 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_hilo"}, {HI, LO}, exp);
        end
        if (read_at >= 0) begin
            check({tag, "_stall_held"}, 64'(stall_bad), 64'd0);
            check({tag, "_no_stall_after"}, 64'(Mult_stall), 64'd0);
        end
        if (chain) begin
            issue(ca, cb, cs);
            check({tag, "_chain_busy"}, 64'(busy), 64'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        Hilo_read = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        Start_mult = 1'b0;
        Mult_sign  = 1'b0;
        A          = 32'd0;
        B          = 32'd0;
        Hilo_read  = 1'b0;
        #12;
        check("rst_hilo", {HI, LO}, 64'd0);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("umax", -1, -1, 1'b0, 32'd0, 32'd0, 1'b0);
        check("umax_const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

        // Abort mid-CALC: outputs must clear asynchronously.
        issue(32'd1234, 32'd5678, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_hilo", {HI, LO}, 64'd0);
        check("abort_busy_done", {62'd0, busy, done}, 64'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        issue(32'd3, 32'd4, 1'b0);
        wait_done("after_rst", -1, -1, 1'b0, 32'd0, 32'd0, 1'b0);
        check("after_rst_lo", {32'd0, LO}, 64'd12);

        issue(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done("neg1x1", -1, -1, 1'b0, 32'd0, 32'd0, 1'b0);
        issue(32'hFFFF_FFF9, 32'd6, 1'b1);
        wait_done("m7x6", -1, -1, 1'b0, 32'd0, 32'd0, 1'b0);
        check("m7x6_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFD6);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("minxmin", -1, -1, 1'b0, 32'd0, 32'd0, 1'b0);
        check("minxmin_const", {HI, LO}, 64'h4000_0000_0000_0000);
        issue(32'h8000_0000, 32'd0, 1'b1);
        wait_done("minx0", -1, -1, 1'b0, 32'd0, 32'd0, 1'b0);

        issue(32'd5, 32'd5, 1'b1);
        wait_done("stall", -1, 10, 1'b0, 32'd0, 32'd0, 1'b0);
        check("stall_lo", {32'd0, LO}, 64'd25);

        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        wait_done("ignored", 4, -1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1001, 1'b0);
        wait_done("chained", -1, -1, 1'b0, 32'd0, 32'd0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            issue($urandom, $urandom, 1'($urandom_range(0, 1)));
            wait_done("rand", -1, -1, 1'b0, 32'd0, 32'd0, 1'b0);
        end

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
